// File: rtl/signed_sub_with_overflow_pipe.sv
// rtl/signed_sub_with_overflow_pipe.sv - two-stage signed subtractor with overflow flag, optional saturation and overflow counter
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid, in_ready   operand handshake
//   a, b                 signed operands (minuend, subtrahend)
//   out_valid, out_ready result handshake
//   diff, overflow       a - b (wrapped or saturated) and signed-overflow flag
//   ovf_count            saturating count of transferred results with overflow set
//   ovf_clear            synchronous clear of ovf_count (wins over an increment)
module signed_sub_with_overflow_pipe #(
    parameter int WIDTH    = 4,
    parameter int SATURATE = 0,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             overflow,
    output logic [CNT_W-1:0] ovf_count,
    input  logic             ovf_clear
);

    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             s1_valid;
    logic             s2_valid;
    logic [WIDTH-1:0] s1_raw;
    logic             s1_amsb;
    logic             s1_ovf;

    logic [WIDTH-1:0] raw;
    logic             ovf_comb;
    logic             s2_load;
    logic             s1_adv;
    logic [WIDTH-1:0] s2_next;
    logic             out_xfer;

    // Overflow is only possible when the operand signs differ; it happened
    // if the wrapped result's sign disagrees with the minuend's sign.
    assign raw      = a - b;
    assign ovf_comb = (a[WIDTH-1] ^ b[WIDTH-1]) & (a[WIDTH-1] ^ raw[WIDTH-1]);

    // Each stage only looks at the stage ahead of it, so out_ready never
    // reaches in_valid combinationally and a full pipe still streams at
    // one result per cycle.
    assign s2_load   = !s2_valid | out_ready;
    assign s1_adv    = !s1_valid | s2_load;
    assign in_ready  = rst_n & s1_adv;
    assign out_valid = s2_valid;
    assign out_xfer  = s2_valid & out_ready;

    // Saturation direction follows the minuend's sign: a negative minuend
    // can only overflow downward, a non-negative one only upward.
    always_comb begin
        s2_next = s1_raw;
        if ((SATURATE != 0) && s1_ovf) begin
            s2_next = s1_amsb ? MIN_NEG : MAX_POS;
        end
    end

    // Stage 1 payload carries no reset; s1_valid qualifies it.
    always_ff @(posedge clk) begin
        if (s1_adv && in_valid) begin
            s1_raw  <= raw;
            s1_amsb <= a[WIDTH-1];
            s1_ovf  <= ovf_comb;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
        end
    end

    // Stage 2 keeps diff/overflow when draining to a bubble; only the
    // valid bit drops, which keeps the outputs free of needless toggles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            diff     <= '0;
            overflow <= 1'b0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                diff     <= s2_next;
                overflow <= s1_ovf;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_count <= '0;
        end else if (ovf_clear) begin
            ovf_count <= '0;
        end else if (out_xfer && overflow && (ovf_count != CNT_MAX)) begin
            ovf_count <= ovf_count + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_signed_sub_with_overflow_pipe.sv
// tb/tb_signed_sub_with_overflow_pipe.sv - directed self-checking bench for signed_sub_with_overflow_pipe (wrap and saturate builds)
module tb_signed_sub_with_overflow_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic       out_ready;
    logic       ovf_clear;

    logic       in_ready0, out_valid0, overflow0;
    logic [3:0] diff0;
    logic [7:0] ovf_count0;
    logic       in_ready1, out_valid1, overflow1;
    logic [3:0] diff1;
    logic [7:0] ovf_count1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    signed_sub_with_overflow_pipe #(.WIDTH(4), .SATURATE(0), .CNT_W(8)) u_dut_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .a(a), .b(b), .out_valid(out_valid0), .out_ready(out_ready),
        .diff(diff0), .overflow(overflow0), .ovf_count(ovf_count0), .ovf_clear(ovf_clear)
    );

    signed_sub_with_overflow_pipe #(.WIDTH(4), .SATURATE(1), .CNT_W(8)) u_dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a), .b(b), .out_valid(out_valid1), .out_ready(out_ready),
        .diff(diff1), .overflow(overflow1), .ovf_count(ovf_count1), .ovf_clear(ovf_clear)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Single operand pair through an empty pipe; checks the two-edge latency
    // and both builds' results, then lets the result transfer.
    task automatic one(input string tag, input logic [3:0] ai, input logic [3:0] bi,
                       input logic [3:0] exp_wrap, input logic [3:0] exp_sat, input logic exp_ovf);
        a = ai; b = bi; in_valid = 1'b1; out_ready = 1'b1;
        check_eq({tag, "_in_ready"}, in_ready0, 1);
        next_cycle();
        in_valid = 1'b0;
        check_eq({tag, "_lat1_valid"}, out_valid0, 0);
        next_cycle();
        check_eq({tag, "_valid"}, out_valid0, 1);
        check_eq({tag, "_valid_sat"}, out_valid1, 1);
        check_eq({tag, "_diff_wrap"}, diff0, exp_wrap);
        check_eq({tag, "_diff_sat"}, diff1, exp_sat);
        check_eq({tag, "_ovf"}, overflow0, exp_ovf);
        check_eq({tag, "_ovf_sat"}, overflow1, exp_ovf);
        next_cycle();
        check_eq({tag, "_drained"}, out_valid0, 0);
    endtask

    logic [3:0] bp_a    [4] = '{4'h1, 4'h7, 4'hC, 4'h6};
    logic [3:0] bp_b    [4] = '{4'h2, 4'hF, 4'h3, 4'h6};
    logic [3:0] bp_wrap [4] = '{4'hF, 4'h8, 4'h9, 4'h0};
    logic [3:0] bp_sat  [4] = '{4'hF, 4'h7, 4'h9, 4'h0};
    logic       bp_ovf  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

    initial begin
        int k_in, k_out, stall;
        bit seen;

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b0; ovf_clear = 1'b0;
        #1;
        check_eq("rst_in_ready", in_ready0, 0);
        check_eq("rst_out_valid", out_valid0, 0);
        check_eq("rst_diff", diff0, 0);
        check_eq("rst_overflow", overflow0, 0);
        check_eq("rst_count", ovf_count0, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();

        one("basic_5m3",   4'h5, 4'h3, 4'h2, 4'h2, 1'b0);
        one("basic_n8mn8", 4'h8, 4'h8, 4'h0, 4'h0, 1'b0);
        one("pos_ovf",     4'h3, 4'hA, 4'h9, 4'h7, 1'b1);
        check_eq("count_after_pos", ovf_count0, 1);
        one("neg_ovf",     4'h8, 4'h1, 4'h7, 4'h8, 1'b1);
        one("b_min_a2",    4'h2, 4'h8, 4'hA, 4'h7, 1'b1);
        one("b_min_a_n1",  4'hF, 4'h8, 4'h7, 4'h7, 1'b0);
        one("b_min_a0",    4'h0, 4'h8, 4'h8, 4'h7, 1'b1);
        one("a_eq_b",      4'h3, 4'h3, 4'h0, 4'h0, 1'b0);
        check_eq("count_directed", ovf_count0, 4);
        check_eq("count_directed_sat", ovf_count1, 4);

        // Backpressure: out_ready low for 3 cycles once the first result shows.
        k_in = 0; k_out = 0; stall = 0; seen = 0;
        for (int cyc = 0; cyc < 40 && k_out < 4; cyc++) begin
            if (out_valid0) seen = 1;
            in_valid = (k_in < 4);
            a = (k_in < 4) ? bp_a[k_in] : 4'h0;
            b = (k_in < 4) ? bp_b[k_in] : 4'h0;
            out_ready = !(seen && stall < 3);
            #1;
            if (seen && stall < 3) begin
                check_eq("bp_in_ready_low", in_ready0, 0);
                check_eq("bp_diff_stable", diff0, bp_wrap[0]);
                stall++;
            end else if (seen) begin
                check_eq("bp_one_per_cycle", out_valid0, 1);
            end
            if (in_valid && in_ready0) k_in++;
            if (out_valid0 && out_ready) begin
                check_eq("bp_diff_wrap", diff0, bp_wrap[k_out]);
                check_eq("bp_diff_sat", diff1, bp_sat[k_out]);
                check_eq("bp_ovf", overflow0, bp_ovf[k_out]);
                k_out++;
            end
            next_cycle();
        end
        in_valid = 1'b0;
        check_eq("bp_all_accepted", k_in, 4);
        check_eq("bp_all_delivered", k_out, 4);
        check_eq("bp_count", ovf_count0, 5);

        // Counter saturation.
        ovf_clear = 1'b1;
        next_cycle();
        ovf_clear = 1'b0;
        check_eq("cnt_cleared", ovf_count0, 0);
        a = 4'h8; b = 4'h1; in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 300; i++) next_cycle();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) next_cycle();
        check_eq("cnt_saturated", ovf_count0, 255);
        check_eq("cnt_saturated_sat", ovf_count1, 255);

        // Clear wins over a simultaneous overflowing transfer.
        in_valid = 1'b1;
        next_cycle();
        in_valid = 1'b0;
        next_cycle();
        check_eq("clr_pri_valid", out_valid0, 1);
        check_eq("clr_pri_ovf", overflow0, 1);
        ovf_clear = 1'b1;
        next_cycle();
        ovf_clear = 1'b0;
        check_eq("clr_priority", ovf_count0, 0);

        // Reset with both stages full.
        one("pre_rst", 4'h8, 4'h1, 4'h7, 4'h8, 1'b1);
        check_eq("pre_rst_count", ovf_count0, 1);
        a = 4'h5; b = 4'h1; in_valid = 1'b1; out_ready = 1'b0;
        next_cycle();
        next_cycle();
        check_eq("full_valid", out_valid0, 1);
        check_eq("full_in_ready", in_ready0, 0);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_out_valid", out_valid0, 0);
        check_eq("midrst_count", ovf_count0, 0);
        check_eq("midrst_diff", diff0, 0);
        check_eq("midrst_in_ready", in_ready0, 0);
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        check_eq("post_rst_no_stale0", out_valid0, 0);
        next_cycle();
        check_eq("post_rst_no_stale1", out_valid0, 0);
        one("post_rst", 4'h6, 4'h2, 4'h4, 4'h4, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/signed_sub_with_overflow_pipe.md
Name: signed_sub_with_overflow_pipe

Overview:
- Pipelined two's-complement subtractor, the inverse of the signed-add-with-overflow block.
- Computes a - b, flags signed overflow, and optionally saturates the result.
- Uses valid/ready handshakes on both sides and keeps a saturating overflow event counter.
- Sits in the arithmetic section as the datapath partner of the signed adder: difference stage of accumulators and comparators.

Parameters:
- WIDTH, 4, operand and result width in bits (two's complement), WIDTH >= 2.
- SATURATE, 0, 1 = clamp overflowed results to max/min representable value; 0 = wrap.
- CNT_W, 8, width of the overflow event counter.

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept operands this cycle
- a  input  WIDTH  minuend, signed
- b  input  WIDTH  subtrahend, signed
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- diff  output  WIDTH  a - b, wrapped or saturated per SATURATE
- overflow  output  1  true signed result did not fit in WIDTH bits
- ovf_count  output  CNT_W  number of accepted results with overflow=1, saturating
- ovf_clear  input  1  synchronous clear of ovf_count

Behaviour:
- Reset (rst_n low, asynchronous): s1_valid=0, s2_valid=0, out_valid=0, diff=0, overflow=0, ovf_count=0.
- While rst_n is low, in_ready=0. Data registers need not be reset except the output regs listed above.
- Stage 1 register stage:
  - Captures a, b and raw = a - b (WIDTH bits, modulo 2^WIDTH).
  - Captures ovf1 = (a[MSB]^b[MSB]) & (a[MSB]^raw[MSB]).
- Stage 2 register stage drives diff/overflow:
  - SATURATE=0: diff = raw.
  - SATURATE=1 and ovf1=1: diff = a[MSB] ? most-negative (100..0) : most-positive (011..1).
- Handshake:
  - Transfer happens when valid & ready are both high on a rising edge.
  - in_valid/a/b must hold until accepted.
  - out_valid/diff/overflow hold stable until out_ready.
- Stall rule, per stage, with no combinational path from out_ready to in_valid:
  - s2 loads when !s2_valid | out_ready.
  - s1 advances when !s1_valid | s2 loads.
  - in_ready = !s1_valid | s2 loads.
  - Full throughput: one result per cycle while out_ready=1.
- Latency: operand accepted at edge N appears on outputs after edge N+1 (out_valid high in cycle N+1 → N+2 window), i.e. 2 register stages.
- Bubbles: s2 clears out_valid when it drains with no new s1 data.
- Ordering: results emerge in acceptance order; none dropped or duplicated under any out_ready pattern.
- ovf_count:
  - Increments on each output transfer (out_valid & out_ready) with overflow=1.
  - Sticks at 2^CNT_W-1.
  - ovf_clear has priority over a simultaneous increment: result 0.
- Boundaries:
  - a = most-negative, b = 1 overflows.
  - b = most-negative overflows iff a >= 0.
  - a = b gives 0, no overflow.
- Reset asserted mid-operation: in-flight results are discarded, outputs return to reset values immediately. First acceptance occurs on the first edge after rst_n deasserts.

Test Plan:
- Basic (WIDTH=4, SATURATE=0, out_ready=1): a=5, b=3 → after 2 edges diff=2, overflow=0. Then a=-8, b=-8 → diff=0, overflow=0.
- Positive overflow: a=3, b=-6 → overflow=1, diff=4'b1001 (-7) with SATURATE=0; diff=4'b0111 (7) with SATURATE=1. ovf_count=1.
- Negative overflow: a=-8, b=1 → overflow=1, diff=4'b0111 with SATURATE=0; 4'b1000 with SATURATE=1. a=2, b=-8 → overflow=1.
- Backpressure: stream 4 pairs back-to-back, hold out_ready=0 for 3 cycles after first out_valid.
  - in_ready drops after 2 pairs are buffered.
  - diff stays stable.
  - All 4 results emerge in order once out_ready=1, one per cycle.
- Counter: 300 overflowing transfers with CNT_W=8 → ovf_count=255. ovf_clear together with an overflowing transfer → 0.
- Reset mid-stream: pulse rst_n low asynchronously (not edge-aligned) with both stages full.
  - out_valid=0 and ovf_count=0 immediately.
  - No stale result after release.
  - A new pair's result appears 2 edges after acceptance.
